// File: rtl/squeeze_psum_writeback_pkg.sv
// Shared definitions for the squeeze partial-sum writeback stage: datapath
// widths, the FSM state type and the per-fire-module layer geometry.
package squeeze_pkg;

  localparam int NUM_PE  = 8;   // filter lanes per beat
  localparam int PSUM_W  = 24;  // signed partial-sum width per lane
  localparam int ACC_W   = 31;  // accumulator width, PSUM_W + 7
  localparam int OUT_W   = 8;   // unsigned activation width
  localparam int ADDR_W  = 16;  // buffer word address width per bank

  localparam int CHCYC_W = 7;
  localparam int SIZE_W  = 6;
  localparam int FGRP_W  = 4;
  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CHCYC_W-1:0] chcyc;  // input channels / 16
    logic [SIZE_W-1:0]  size;   // feature-map side
    logic [FGRP_W-1:0]  fgrp;   // squeeze filters / 8
  } fire_cfg_t;

  // Layer geometry of fire2..fire9 (firesel 0..7) for the squeeze stage.
  function automatic fire_cfg_t fire_cfg(input logic [2:0] firesel);
    fire_cfg_t c;
    case (firesel)
      3'd0:    c = '{chcyc: 7'd4,  size: 6'd55, fgrp: 4'd2};
      3'd1:    c = '{chcyc: 7'd8,  size: 6'd55, fgrp: 4'd2};
      3'd2:    c = '{chcyc: 7'd8,  size: 6'd27, fgrp: 4'd4};
      3'd3:    c = '{chcyc: 7'd16, size: 6'd27, fgrp: 4'd4};
      3'd4:    c = '{chcyc: 7'd16, size: 6'd13, fgrp: 4'd6};
      3'd5:    c = '{chcyc: 7'd24, size: 6'd13, fgrp: 4'd6};
      3'd6:    c = '{chcyc: 7'd24, size: 6'd13, fgrp: 4'd8};
      3'd7:    c = '{chcyc: 7'd32, size: 6'd13, fgrp: 4'd8};
      default: c = '{chcyc: 7'd1,  size: 6'd1,  fgrp: 4'd1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/squeeze_psum_writeback_if.sv
// Partial-sum input, bias lookup and output-buffer write bus of the squeeze
// writeback stage. master = the writeback block, slave = its environment.
interface squeeze_psum_writeback_if;
  import squeeze_pkg::*;

  logic                      psum_valid;
  logic [NUM_PE*PSUM_W-1:0]  psum_data;
  logic [NUM_PE*ACC_W-1:0]   bias_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [NUM_PE*OUT_W-1:0]   wr_data;
  logic [FGRP_W-1:0]         fgrp_idx;

  modport master (
    input  psum_valid, psum_data, bias_data,
    output wr_en, wr_addr, wr_data, fgrp_idx
  );

  modport slave (
    output psum_valid, psum_data, bias_data,
    input  wr_en, wr_addr, wr_data, fgrp_idx
  );

endinterface

// File: rtl/squeeze_psum_writeback_psum_lane.sv
// One filter lane: accumulates the channel-group partial sums of a pixel and
// forms the finished activation (bias, ReLU, shift, saturate) combinationally
// on the final beat so the top can register it together with the address.
module psum_lane
  import squeeze_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat,    // accepted beat this cycle
  input  logic                     first,   // beat carries channel group 0
  input  logic signed [PSUM_W-1:0] psum,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic [SHIFT_W-1:0]       shift,
  output logic [OUT_W-1:0]         result
);

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] psum_ext_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W:0]   sum_s;
  logic signed [ACC_W:0]   shifted_s;

  // Sign-extend the beat, pick the running sum (ignored on group 0 so a
  // stale accumulator never leaks into a new pixel) and finish the pixel.
  // The sum is one bit wider than the accumulator so an extreme bias cannot wrap.
  always_comb begin
    psum_ext_s = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
    base_s     = first ? {ACC_W{1'b0}} : acc_r;
    sum_s      = {base_s[ACC_W-1], base_s}
               + {psum_ext_s[ACC_W-1], psum_ext_s}
               + {bias[ACC_W-1], bias};
    shifted_s  = sum_s >>> shift;
    if (sum_s[ACC_W]) begin
      result = {OUT_W{1'b0}};
    end else if (|shifted_s[ACC_W:OUT_W]) begin
      result = {OUT_W{1'b1}};
    end else begin
      result = shifted_s[OUT_W-1:0];
    end
  end

  // Running accumulator: restart on group 0, add on later groups, hold on gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (beat) begin
      acc_r <= first ? psum_ext_s : acc_r + psum_ext_s;
    end
  end

endmodule

// File: rtl/squeeze_psum_writeback.sv
// Squeeze-stage partial-sum writeback: walks grp/col/line/fgrp over the PE
// array beats, finishes each pixel in eight lanes and writes the result to
// the filter-major squeeze output buffer.
module squeeze_psum_writeback
  import squeeze_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CHCYC_W-1:0]         cfg_chcyc,
  input  logic [SIZE_W-1:0]          cfg_size,
  input  logic [FGRP_W-1:0]          cfg_fgrp,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  squeeze_psum_writeback_if.master   bus,
  output logic                       busy,
  output logic                       done
);

  state_t                state_r;
  logic [CHCYC_W-1:0]    chcyc_r;
  logic [SIZE_W-1:0]     size_r;
  logic [FGRP_W-1:0]     nfgrp_r;
  logic [SHIFT_W-1:0]    shift_r;
  logic [11:0]           sq_r;      // size*size, one filter group's footprint
  logic [CHCYC_W-1:0]    grp_r;
  logic [SIZE_W-1:0]     col_r;
  logic [SIZE_W-1:0]     line_r;
  logic [FGRP_W-1:0]     fgrp_r;
  logic                  wr_en_r;
  logic [ADDR_W-1:0]     wr_addr_r;
  logic [NUM_PE*OUT_W-1:0] wr_data_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  beat_s;
  logic                  first_s;
  logic                  last_grp_s;
  logic                  last_col_s;
  logic                  last_line_s;
  logic                  last_fgrp_s;
  logic [ADDR_W-1:0]     fgrp_base_s;
  logic [ADDR_W-1:0]     line_base_s;
  logic [ADDR_W-1:0]     addr_s;
  logic [NUM_PE*OUT_W-1:0] lane_res_s;

  // Beat qualification, counter terminal counts and the write address of
  // the pixel currently being finished (counters before they advance).
  always_comb begin
    beat_s      = (state_r == RUN) && bus.psum_valid;
    first_s     = (grp_r == {CHCYC_W{1'b0}});
    last_grp_s  = (grp_r == chcyc_r - 7'd1);
    last_col_s  = (col_r == size_r - 6'd1);
    last_line_s = (line_r == size_r - 6'd1);
    last_fgrp_s = (fgrp_r == nfgrp_r - 4'd1);
    fgrp_base_s = ADDR_W'(fgrp_r) * ADDR_W'(sq_r);
    line_base_s = ADDR_W'(line_r) * ADDR_W'(size_r);
    addr_s      = fgrp_base_s + line_base_s + ADDR_W'(col_r);
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
    psum_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .beat   (beat_s),
      .first  (first_s),
      .psum   (bus.psum_data[k*PSUM_W +: PSUM_W]),
      .bias   (bus.bias_data[k*ACC_W +: ACC_W]),
      .shift  (shift_r),
      .result (lane_res_s[k*OUT_W +: OUT_W])
    );
  end

  // Layer FSM, loop counters and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      chcyc_r   <= {CHCYC_W{1'b0}};
      size_r    <= {SIZE_W{1'b0}};
      nfgrp_r   <= {FGRP_W{1'b0}};
      shift_r   <= {SHIFT_W{1'b0}};
      sq_r      <= 12'd0;
      grp_r     <= {CHCYC_W{1'b0}};
      col_r     <= {SIZE_W{1'b0}};
      line_r    <= {SIZE_W{1'b0}};
      fgrp_r    <= {FGRP_W{1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {(NUM_PE*OUT_W){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          if (start) begin
            state_r <= RUN;
            chcyc_r <= cfg_chcyc;
            size_r  <= cfg_size;
            nfgrp_r <= cfg_fgrp;
            shift_r <= cfg_shift;
            sq_r    <= 12'(cfg_size) * 12'(cfg_size);
            grp_r   <= {CHCYC_W{1'b0}};
            col_r   <= {SIZE_W{1'b0}};
            line_r  <= {SIZE_W{1'b0}};
            fgrp_r  <= {FGRP_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (beat_s && last_grp_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_s;
            wr_data_r <= lane_res_s;
            grp_r     <= {CHCYC_W{1'b0}};
            if (!last_col_s) begin
              col_r <= col_r + 6'd1;
            end else begin
              col_r <= {SIZE_W{1'b0}};
              if (!last_line_s) begin
                line_r <= line_r + 6'd1;
              end else begin
                line_r <= {SIZE_W{1'b0}};
                if (!last_fgrp_s) begin
                  fgrp_r <= fgrp_r + 4'd1;
                end else begin
                  fgrp_r  <= {FGRP_W{1'b0}};
                  state_r <= DONE;
                end
              end
            end
          end else if (beat_s) begin
            wr_en_r <= 1'b0;
            grp_r   <= grp_r + 7'd1;
          end else begin
            wr_en_r <= 1'b0;
          end
        end
        DONE: begin
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // A reset landing while a finished write sits in the output register must
  // discard it immediately, so the strobes are masked by rst.
  assign bus.wr_en    = wr_en_r & ~rst;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.fgrp_idx = fgrp_r;
  assign busy         = busy_r & ~rst;
  assign done         = done_r & ~rst;

endmodule

// File: tb/tb_squeeze_psum_writeback.sv
// Bench for squeeze_psum_writeback: directed and randomized layers checked
// against a pixel-level arithmetic model (sum of beats + bias, ReLU, shift,
// saturate) and a queue of expected buffer writes.
module tb_squeeze_psum_writeback;
  import squeeze_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  cfg_chcyc;
  logic [5:0]  cfg_size;
  logic [3:0]  cfg_fgrp;
  logic [4:0]  cfg_shift;
  logic        busy;
  logic        done;

  squeeze_psum_writeback_if bus ();

  squeeze_psum_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_chcyc (cfg_chcyc),
    .cfg_size  (cfg_size),
    .cfg_fgrp  (cfg_fgrp),
    .cfg_shift (cfg_shift),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  bias_tab [8][8];
  int  psum_c [8];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  last_wr_cyc = 0;
  int  done_cyc    = -1;

  // Upstream bias lookup keyed by the DUT's current filter group.
  always_comb begin
    for (int k = 0; k < 8; k++)
      bus.bias_data[k*ACC_W +: ACC_W] = ACC_W'(bias_tab[bus.fgrp_idx[2:0]][k]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] quant(input longint s, input int sh);
    longint r;
    if (s < 0) return 8'd0;
    r = s >>> sh;
    if (r > 255) return 8'hFF;
    return 8'(r);
  endfunction

  // One clock; every observed write is matched against the expected queue.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_en === 1'b1) begin
      chk("spurious_wr", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, e.addr);
        chk("wr_data", bus.wr_data, e.data);
      end
      last_wr_cyc = cyc;
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_layer(input int chcyc, input int size, input int nf, input int sh,
                           input bit rnd, input bit gaps, input bit poke, input int rst_pix);
    longint sum [8];
    int     p;
    int     pix;
    wr_t    e;
    cfg_chcyc = 7'(chcyc);
    cfg_size  = 6'(size);
    cfg_fgrp  = 4'(nf);
    cfg_shift = 5'(sh);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("busy_after_start", busy, 64'd1);
    cfg_chcyc = 7'($urandom_range(1, 64));
    cfg_size  = 6'($urandom_range(1, 55));
    cfg_fgrp  = 4'($urandom_range(1, 8));
    cfg_shift = 5'($urandom_range(0, 31));
    done_cyc  = -1;
    pix       = 0;
    for (int f = 0; f < nf; f++) begin
      for (int ln = 0; ln < size; ln++) begin
        for (int c = 0; c < size; c++) begin
          for (int k = 0; k < 8; k++) sum[k] = 0;
          for (int g = 0; g < chcyc; g++) begin
            for (int k = 0; k < 8; k++) begin
              p = rnd ? int'($urandom_range(0, 8191)) - 4096 : psum_c[k];
              sum[k] += p;
              bus.psum_data[k*PSUM_W +: PSUM_W] = 24'(p);
            end
            bus.psum_valid = 1'b1;
            if (poke && pix == 1 && g == 0) begin
              start    = 1'b1;
              cfg_size = 6'd9;
            end
            chk("fgrp_idx", bus.fgrp_idx, 64'(f));
            if (g == chcyc - 1 && pix == rst_pix) begin
              @(posedge clk);
              #1;
              rst = 1'b1;
              bus.psum_valid = 1'b0;
              #1;
              chk("rst_wr_en", bus.wr_en, 64'd0);
              chk("rst_busy", busy, 64'd0);
              @(posedge clk);
              #1;
              rst = 1'b0;
              chk("rst_wr_en_after", bus.wr_en, 64'd0);
              chk("rst_fgrp_idx", bus.fgrp_idx, 64'd0);
              chk("rst_pending", 64'(exp_q.size()), 64'd0);
              return;
            end
            if (g == chcyc - 1) begin
              e.addr = 16'(f*size*size + ln*size + c);
              e.data = '0;
              for (int k = 0; k < 8; k++)
                e.data[k*8 +: 8] = quant(sum[k] + longint'(bias_tab[f][k]), sh);
              exp_q.push_back(e);
            end
            tick();
            start = 1'b0;
            if (gaps) begin
              bus.psum_valid = 1'b0;
              bus.psum_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
              tick();
            end
          end
          pix++;
        end
      end
    end
    bus.psum_valid = 1'b0;
    for (int i = 0; i < 8 && done_cyc < 0; i++) tick();
    chk("done_after_last_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    chk("busy_at_done", busy, 64'd0);
    tick();
    chk("done_pulse_width", done, 64'd0);
  endtask

  task automatic set_psum_all(input int v);
    for (int k = 0; k < 8; k++) psum_c[k] = v;
  endtask

  task automatic clear_bias();
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 8; k++) bias_tab[f][k] = 0;
  endtask

  task automatic rand_bias(input int span);
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 8; k++) bias_tab[f][k] = int'($urandom_range(0, 2*span)) - span;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    cfg_chcyc      = 7'd0;
    cfg_size       = 6'd0;
    cfg_fgrp       = 4'd0;
    cfg_shift      = 5'd0;
    bus.psum_valid = 1'b0;
    bus.psum_data  = '0;
    clear_bias();
    set_psum_all(0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_wr_en", bus.wr_en, 64'd0);
    chk("reset_wr_addr", bus.wr_addr, 64'd0);
    chk("reset_wr_data", bus.wr_data, 64'd0);
    chk("reset_fgrp_idx", bus.fgrp_idx, 64'd0);
    chk("reset_busy", busy, 64'd0);
    chk("reset_done", done, 64'd0);

    // Beats presented while idle are dropped.
    bus.psum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.psum_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    bus.psum_valid = 1'b0;
    chk("idle_busy", busy, 64'd0);

    // Test 1: all +1, four groups, 2x2 map -> data 4, addresses 0..3.
    set_psum_all(1);
    run_layer(4, 2, 1, 0, 1'b0, 1'b0, 1'b0, -1);

    // Test 2: ReLU on lane 3, shift on lane 0, assorted others.
    for (int k = 0; k < 8; k++) psum_c[k] = 7*k - 20;
    psum_c[0] = 100;
    psum_c[3] = -5;
    bias_tab[0][3] = 10;
    run_layer(4, 2, 1, 1, 1'b0, 1'b0, 1'b0, -1);
    clear_bias();

    // Test 3: saturation high, deepest negative and positive accumulation.
    set_psum_all(1000);
    run_layer(4, 1, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    set_psum_all(-8388608);
    run_layer(64, 1, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    set_psum_all(8388607);
    run_layer(64, 1, 1, 22, 1'b0, 1'b0, 1'b0, -1);

    // Test 4: chcyc=1, 3x3 map, two filter groups with distinct biases.
    rand_bias(3000);
    run_layer(1, 3, 2, 4, 1'b1, 1'b0, 1'b0, -1);
    clear_bias();

    // Test 5: gapped beats and a start pulse while busy.
    set_psum_all(1);
    run_layer(4, 2, 1, 0, 1'b0, 1'b1, 1'b1, -1);

    // Test 6: reset right after the second pixel finishes, then a clean layer.
    run_layer(4, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1);
    run_layer(4, 2, 1, 0, 1'b0, 1'b0, 1'b0, -1);

    // Every filter group in use.
    rand_bias(2000);
    run_layer(1, 2, 8, 3, 1'b1, 1'b0, 1'b0, -1);

    // Randomized layers.
    for (int t = 0; t < 4; t++) begin
      rand_bias(5000);
      run_layer($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(0, 6), 1'b1, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
